// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the outstanding-transaction memory controller.
// Holds the default word widths, the derived FIFO word widths, the bit
// positions of each field inside a request-FIFO word, and the encoding of
// the read/write flag. The package has no ports.
package mem_ctrl_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int ADDR_WIDTH     = 31;
  localparam int TID_WIDTH      = 16;

  localparam int REQ_WIDTH      = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int DP_DATA_WIDTH  = TID_WIDTH + REQ_WIDTH;
  localparam int VPI_DATA_WIDTH = TID_WIDTH + DATA_WIDTH;

  // Layout of a request-FIFO word: {tid, rw, addr, data}, MSB first.
  localparam int TID_MSB  = DP_DATA_WIDTH - 1;
  localparam int TID_LSB  = REQ_WIDTH;
  localparam int RW_BIT   = REQ_WIDTH - 1;
  localparam int ADDR_MSB = ADDR_WIDTH + DATA_WIDTH - 1;
  localparam int ADDR_LSB = DATA_WIDTH;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/mem_tag_table.sv
// Outstanding-transaction table.
// Tracks which backend tags are in use, remembers the originating TID and
// read/write flag of each in-flight transaction, and offers the lowest free
// tag for the next allocation.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   alloc_en/tid/rw       claim alloc_tag and record its TID and rw flag
//   free_en/free_tag      release a tag on a completed response
//   lookup_tag            tag whose entry is presented on lookup_*
//   any_free, alloc_tag   at least one free slot; lowest-index free slot
//   lookup_valid/tid/rw   contents of the slot named by lookup_tag
//   count                 number of allocated slots (registered)
module mem_tag_table #(
  parameter int MAX_OUTSTANDING = 8,
  parameter int TID_WIDTH       = 16,
  parameter int TAG_WIDTH       = $clog2(MAX_OUTSTANDING)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alloc_en,
  input  logic [TID_WIDTH-1:0] alloc_tid,
  input  logic                 alloc_rw,
  input  logic                 free_en,
  input  logic [TAG_WIDTH-1:0] free_tag,
  input  logic [TAG_WIDTH-1:0] lookup_tag,
  output logic                 any_free,
  output logic [TAG_WIDTH-1:0] alloc_tag,
  output logic                 lookup_valid,
  output logic [TID_WIDTH-1:0] lookup_tid,
  output logic                 lookup_rw,
  output logic [TAG_WIDTH:0]   count
);
  import mem_ctrl_pkg::*;

  logic [MAX_OUTSTANDING-1:0] valid_r;
  logic [MAX_OUTSTANDING-1:0] valid_nxt_s;
  logic [TID_WIDTH-1:0]       tid_r [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] rw_r;
  logic [TAG_WIDTH:0]         count_r;

  // Scanning from the top down leaves the lowest clear bit as the result.
  function automatic logic [TAG_WIDTH-1:0] lowest_free(input logic [MAX_OUTSTANDING-1:0] v);
    lowest_free = {TAG_WIDTH{1'b0}};
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
      if (!v[i]) begin
        lowest_free = TAG_WIDTH'(i);
      end else begin
        lowest_free = lowest_free;
      end
    end
  endfunction

  function automatic logic [TAG_WIDTH:0] popcount(input logic [MAX_OUTSTANDING-1:0] v);
    popcount = {(TAG_WIDTH+1){1'b0}};
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      popcount = popcount + (TAG_WIDTH+1)'(v[i]);
    end
  endfunction

  // Next bitmap. Allocation picks from the pre-edge bitmap, so the slot being
  // freed this cycle can never be the one allocated; it is reusable next cycle.
  always_comb begin
    valid_nxt_s = valid_r;
    if (free_en) begin
      valid_nxt_s[free_tag] = 1'b0;
    end else begin
      valid_nxt_s = valid_nxt_s;
    end
    if (alloc_en) begin
      valid_nxt_s[alloc_tag] = 1'b1;
    end else begin
      valid_nxt_s = valid_nxt_s;
    end
  end

  // Free-slot search and lookup of the responding slot.
  always_comb begin
    any_free     = ~(&valid_r);
    alloc_tag    = lowest_free(valid_r);
    lookup_valid = valid_r[lookup_tag];
    lookup_tid   = tid_r[lookup_tag];
    lookup_rw    = rw_r[lookup_tag];
    count        = count_r;
  end

  // Slot ownership bitmap and its registered occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= {MAX_OUTSTANDING{1'b0}};
      count_r <= {(TAG_WIDTH+1){1'b0}};
    end else begin
      valid_r <= valid_nxt_s;
      count_r <= popcount(valid_nxt_s);
    end
  end

  // Per-slot TID and rw storage; only read while the slot is valid.
  always_ff @(posedge clk) begin
    if (alloc_en) begin
      tid_r[alloc_tag] <= alloc_tid;
      rw_r[alloc_tag]  <= alloc_rw;
    end
  end

endmodule

// File: rtl/mem_controller_ot.sv
// Memory controller with an outstanding-transaction table.
// Pops {tid, rw, addr, data} requests from a first-word-fall-through FIFO,
// allocates a backend tag, issues the request through a one-entry register,
// and maps out-of-order backend responses back to {tid, data} pushes on the
// response FIFO.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   incoming_data/empty_signal request FIFO head and empty flag
//   read_ctr                   request FIFO pop
//   outgoing_data/write_ctr    response word and push; full_signal is FIFO full
//   be_req_*                   backend request channel (valid/ready)
//   be_rsp_*                   backend response channel (valid/ready)
//   outstanding_cnt            allocated slots
//   err_unknown_tag            sticky: response arrived for a free tag
module mem_controller_ot #(
  parameter int DATA_WIDTH      = mem_ctrl_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH      = mem_ctrl_pkg::ADDR_WIDTH,
  parameter int TID_WIDTH       = mem_ctrl_pkg::TID_WIDTH,
  parameter int MAX_OUTSTANDING = 8,
  parameter int TAG_WIDTH       = $clog2(MAX_OUTSTANDING),
  parameter int REQ_WIDTH       = 1 + ADDR_WIDTH + DATA_WIDTH,
  parameter int DP_DATA_WIDTH   = TID_WIDTH + REQ_WIDTH,
  parameter int VPI_DATA_WIDTH  = TID_WIDTH + DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DP_DATA_WIDTH-1:0]  incoming_data,
  input  logic                      empty_signal,
  output logic                      read_ctr,
  output logic [VPI_DATA_WIDTH-1:0] outgoing_data,
  input  logic                      full_signal,
  output logic                      write_ctr,
  output logic                      be_req_valid,
  input  logic                      be_req_ready,
  output logic                      be_req_rw,
  output logic [ADDR_WIDTH-1:0]     be_req_addr,
  output logic [DATA_WIDTH-1:0]     be_req_data,
  output logic [TAG_WIDTH-1:0]      be_req_tag,
  input  logic                      be_rsp_valid,
  output logic                      be_rsp_ready,
  input  logic [TAG_WIDTH-1:0]      be_rsp_tag,
  input  logic [DATA_WIDTH-1:0]     be_rsp_data,
  output logic [TAG_WIDTH:0]        outstanding_cnt,
  output logic                      err_unknown_tag
);
  import mem_ctrl_pkg::*;

  logic [TID_WIDTH-1:0]  in_tid_s;
  logic                  in_rw_s;
  logic [ADDR_WIDTH-1:0] in_addr_s;
  logic [DATA_WIDTH-1:0] in_data_s;

  logic                  any_free_s;
  logic [TAG_WIDTH-1:0]  alloc_tag_s;
  logic                  lookup_valid_s;
  logic [TID_WIDTH-1:0]  lookup_tid_s;
  logic                  lookup_rw_s;

  logic                  pop_s;
  logic                  rsp_known_s;
  logic                  rsp_fire_s;

  logic                  req_v_r;
  logic                  req_rw_r;
  logic [ADDR_WIDTH-1:0] req_addr_r;
  logic [DATA_WIDTH-1:0] req_data_r;
  logic [TAG_WIDTH-1:0]  req_tag_r;
  logic                  err_r;

  assign in_tid_s  = incoming_data[DP_DATA_WIDTH-1 -: TID_WIDTH];
  assign in_rw_s   = incoming_data[REQ_WIDTH-1];
  assign in_addr_s = incoming_data[DATA_WIDTH +: ADDR_WIDTH];
  assign in_data_s = incoming_data[DATA_WIDTH-1:0];

  mem_tag_table #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .TID_WIDTH       (TID_WIDTH),
    .TAG_WIDTH       (TAG_WIDTH)
  ) u_tag_table (
    .clk          (clk),
    .reset        (reset),
    .alloc_en     (pop_s),
    .alloc_tid    (in_tid_s),
    .alloc_rw     (in_rw_s),
    .free_en      (rsp_fire_s),
    .free_tag     (be_rsp_tag),
    .lookup_tag   (be_rsp_tag),
    .any_free     (any_free_s),
    .alloc_tag    (alloc_tag_s),
    .lookup_valid (lookup_valid_s),
    .lookup_tid   (lookup_tid_s),
    .lookup_rw    (lookup_rw_s),
    .count        (outstanding_cnt)
  );

  // Pop and response handshakes. A pop is allowed when the request register
  // is empty or draining this cycle, which lets requests stream one per cycle.
  // Unknown-tag responses are always accepted so they cannot stall the backend.
  always_comb begin
    pop_s       = !reset && !empty_signal && any_free_s && (!req_v_r || be_req_ready);
    rsp_known_s = be_rsp_valid && lookup_valid_s;
    rsp_fire_s  = !reset && rsp_known_s && !full_signal;
    read_ctr    = pop_s;
    write_ctr   = rsp_fire_s;
    if (lookup_valid_s) begin
      be_rsp_ready = !full_signal;
    end else begin
      be_rsp_ready = 1'b1;
    end
    if (rsp_known_s && !reset) begin
      outgoing_data = {lookup_tid_s,
                       (lookup_rw_s == RW_READ) ? be_rsp_data : {DATA_WIDTH{1'b0}}};
    end else begin
      outgoing_data = {VPI_DATA_WIDTH{1'b0}};
    end
  end

  // One-entry issue register; contents hold steady while valid and not ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_v_r    <= 1'b0;
      req_rw_r   <= 1'b0;
      req_addr_r <= {ADDR_WIDTH{1'b0}};
      req_data_r <= {DATA_WIDTH{1'b0}};
      req_tag_r  <= {TAG_WIDTH{1'b0}};
    end else if (pop_s) begin
      req_v_r    <= 1'b1;
      req_rw_r   <= in_rw_s;
      req_addr_r <= in_addr_s;
      req_data_r <= in_data_s;
      req_tag_r  <= alloc_tag_s;
    end else if (req_v_r && be_req_ready) begin
      req_v_r    <= 1'b0;
    end
  end

  // Sticky flag for responses naming a slot that is not in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_r <= 1'b0;
    end else if (be_rsp_valid && !lookup_valid_s) begin
      err_r <= 1'b1;
    end
  end

  assign be_req_valid    = req_v_r;
  assign be_req_rw       = req_rw_r;
  assign be_req_addr     = req_addr_r;
  assign be_req_data     = req_data_r;
  assign be_req_tag      = req_tag_r;
  assign err_unknown_tag = err_r;

endmodule
